// File: rtl/tlp_wrr_scheduler.sv
// -----------------------------------------------------------------------------
// tlp_wrr_scheduler
//
// Packet-level weighted round-robin scheduler for the TLP transmit path.
// A 16-slot priority table holds queue ids. Each slot's weight is the number
// of times its id appears in the table. In SCAN the slot under the pointer is
// examined once per cycle. A non-empty queue is granted and keeps the grant
// until its end-of-packet word is popped or MAX_WORDS words have been popped.
// An empty slot is skipped.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   cfg_we     in   priority table write enable (ignored during reset)
//   cfg_addr   in   [3:0] table slot to write
//   cfg_data   in   [1:0] queue id stored in the slot
//   q_empty    in   [3:0] bit i = queue i empty
//   q_eop      in   [3:0] bit i = head word of queue i ends its packet
//   out_ready  in   downstream accepts a word this cycle
//   pop        out  [3:0] one-hot dequeue strobe for the granted queue
//   out_valid  out  granted queue presents a word downstream
//   out_id     out  [1:0] id of the granted queue (0 while scanning)
//   len_err    out  one-cycle pulse on forced release at MAX_WORDS
// -----------------------------------------------------------------------------
module tlp_wrr_scheduler #(
    parameter int MAX_WORDS = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cfg_we,
    input  logic [3:0] cfg_addr,
    input  logic [1:0] cfg_data,
    input  logic [3:0] q_empty,
    input  logic [3:0] q_eop,
    input  logic       out_ready,
    output logic [3:0] pop,
    output logic       out_valid,
    output logic [1:0] out_id,
    output logic       len_err
);

    typedef enum logic [0:0] {
        SCAN = 1'b0,
        XFER = 1'b1
    } state_t;

    localparam logic [7:0] MAX_WORDS_C = 8'(MAX_WORDS);

    state_t      state_r;
    state_t      state_s;
    logic [1:0]  table_r [16];
    logic [3:0]  ptr_r;
    logic [3:0]  ptr_s;
    logic [1:0]  gnt_id_r;
    logic [1:0]  gnt_id_s;
    logic [7:0]  word_cnt_r;
    logic [7:0]  word_cnt_s;
    logic        len_err_r;
    logic        len_err_s;

    logic [1:0]  scan_q_s;
    logic        grant_valid_s;
    logic        pop_fire_s;
    logic [7:0]  word_cnt_inc_s;

    // Queue id under the scan pointer; a same-cycle write to this slot is
    // only seen on the next read because the table is registered.
    assign scan_q_s = table_r[ptr_r];

    // The granted queue has a word to present; reset forces this low so an
    // in-flight packet is abandoned without popping.
    assign grant_valid_s = (state_r == XFER) && !reset && !q_empty[gnt_id_r];

    assign pop_fire_s     = grant_valid_s && out_ready;
    assign word_cnt_inc_s = word_cnt_r + 8'd1;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= SCAN;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath registers: pointer, grant id, packet word counter, error pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_r      <= 4'd0;
            gnt_id_r   <= 2'd0;
            word_cnt_r <= 8'd0;
            len_err_r  <= 1'b0;
        end else begin
            ptr_r      <= ptr_s;
            gnt_id_r   <= gnt_id_s;
            word_cnt_r <= word_cnt_s;
            len_err_r  <= len_err_s;
        end
    end

    // Priority table: reset to slot index mod 4, writable in any state.
    // The active grant is held in gnt_id_r, so rewriting its slot is harmless.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                table_r[i] <= 2'(i);
            end
        end else if (cfg_we) begin
            table_r[cfg_addr] <= cfg_data;
        end else begin
            table_r[cfg_addr] <= table_r[cfg_addr];
        end
    end

    // Next-state and datapath next-value logic.
    always_comb begin
        state_s    = state_r;
        ptr_s      = ptr_r;
        gnt_id_s   = gnt_id_r;
        word_cnt_s = word_cnt_r;
        len_err_s  = 1'b0;
        case (state_r)
            SCAN: begin
                if (!q_empty[scan_q_s]) begin
                    // Grant; pointer stays on this slot until release.
                    state_s    = XFER;
                    gnt_id_s   = scan_q_s;
                    word_cnt_s = 8'd0;
                end else begin
                    ptr_s = ptr_r + 4'd1;
                end
            end
            XFER: begin
                if (pop_fire_s) begin
                    word_cnt_s = word_cnt_inc_s;
                    if (q_eop[gnt_id_r]) begin
                        // Normal release; eop wins over the length limit.
                        state_s = SCAN;
                        ptr_s   = ptr_r + 4'd1;
                    end else if (word_cnt_inc_s == MAX_WORDS_C) begin
                        state_s   = SCAN;
                        ptr_s     = ptr_r + 4'd1;
                        len_err_s = 1'b1;
                    end else begin
                        state_s = XFER;
                    end
                end else begin
                    // Stalled (queue empty or downstream busy): hold grant.
                    state_s = XFER;
                end
            end
            default: begin
                state_s = SCAN;
            end
        endcase
    end

    // Outputs: combinational from registered grant and live queue status.
    always_comb begin
        pop       = 4'd0;
        out_valid = 1'b0;
        out_id    = 2'd0;
        case (state_r)
            XFER: begin
                if (!reset) begin
                    out_id    = gnt_id_r;
                    out_valid = grant_valid_s;
                    pop[gnt_id_r] = pop_fire_s;
                end else begin
                    out_id = 2'd0;
                end
            end
            SCAN: begin
                out_id = 2'd0;
            end
            default: begin
                out_id = 2'd0;
            end
        endcase
    end

    assign len_err = len_err_r;

endmodule

// File: tb/tb_tlp_wrr_scheduler.sv
module tb_tlp_wrr_scheduler;

    logic       clk;
    logic       reset;
    logic       cfg_we;
    logic [3:0] cfg_addr;
    logic [1:0] cfg_data;
    logic [3:0] q_empty;
    logic [3:0] q_eop;
    logic       out_ready;
    logic [3:0] pop;
    logic       out_valid;
    logic [1:0] out_id;
    logic       len_err;

    int checks   = 0;
    int failures = 0;

    logic [1:0] prog [16];
    int         gcount [4];

    tlp_wrr_scheduler #(.MAX_WORDS(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .q_empty   (q_empty),
        .q_eop     (q_eop),
        .out_ready (out_ready),
        .pop       (pop),
        .out_valid (out_valid),
        .out_id    (out_id),
        .len_err   (len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        reset  = 1'b1;
        cfg_we = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        prog = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd2,
                 2'd0, 2'd0, 2'd0, 2'd3, 2'd0, 2'd0, 2'd0, 2'd1};
        for (int i = 0; i < 4; i++) gcount[i] = 0;

        reset = 1'b1; cfg_we = 1'b0; cfg_addr = 4'd0; cfg_data = 2'd0;
        q_empty = 4'hF; q_eop = 4'h0; out_ready = 1'b0;
        tick();
        tick();

        // Reset state, with busy queues and ready downstream
        q_empty = 4'h0; out_ready = 1'b1; #1;
        chk("rst_valid", 8'(out_valid), 8'd0);
        chk("rst_pop",   8'(pop),       8'd0);
        chk("rst_id",    8'(out_id),    8'd0);
        chk("rst_len",   8'(len_err),   8'd0);

        // Default table, all busy, 1-word packets: 0,1,2,3,0,...
        q_eop = 4'hF; reset = 1'b0; #1;
        for (int g = 0; g < 8; g++) begin
            chk("t1_gap_valid", 8'(out_valid), 8'd0);
            tick();
            chk("t1_valid", 8'(out_valid), 8'd1);
            chk("t1_id",    8'(out_id),    8'(g % 4));
            chk("t1_pop",   8'(pop),       8'(1 << (g % 4)));
            tick();
        end

        // Only queue 2 busy: slots 0,1 skipped, valid in cycle 3
        apply_reset();
        q_empty = 4'b1011; q_eop = 4'hF; out_ready = 1'b1; reset = 1'b0; #1;
        chk("t3_c0_valid", 8'(out_valid), 8'd0);
        tick();
        chk("t3_c1_valid", 8'(out_valid), 8'd0);
        tick();
        chk("t3_c2_valid", 8'(out_valid), 8'd0);
        tick();
        chk("t3_c3_valid", 8'(out_valid), 8'd1);
        chk("t3_c3_id",    8'(out_id),    8'd2);

        // Program weighted table while idle, then 16 grants in table order
        apply_reset();
        q_empty = 4'hF; reset = 1'b0;
        for (int s = 0; s < 16; s++) begin
            cfg_we = 1'b1; cfg_addr = 4'(s); cfg_data = prog[s];
            tick();
        end
        cfg_we = 1'b0; q_empty = 4'h0; q_eop = 4'hF; out_ready = 1'b1; #1;
        for (int g = 0; g < 16; g++) begin
            chk("t2_gap_valid", 8'(out_valid), 8'd0);
            tick();
            chk("t2_id", 8'(out_id), 8'(prog[g]));
            gcount[out_id] = gcount[out_id] + 1;
            tick();
        end
        chk("t2_cnt_q0", 8'(gcount[0]), 8'd12);
        chk("t2_cnt_q1", 8'(gcount[1]), 8'd2);
        chk("t2_cnt_q2", 8'(gcount[2]), 8'd1);
        chk("t2_cnt_q3", 8'(gcount[3]), 8'd1);

        // Queue 1, 3-word packet with toggling ready
        apply_reset();
        q_empty = 4'b1101; q_eop = 4'h0; out_ready = 1'b1; reset = 1'b0; #1;
        chk("t4_c0_valid", 8'(out_valid), 8'd0);
        tick();
        chk("t4_c1_valid", 8'(out_valid), 8'd0);
        tick();
        chk("t4_c2_pop", 8'(pop), 8'h2);
        tick();
        out_ready = 1'b0; #1;
        chk("t4_c3_valid", 8'(out_valid), 8'd1);
        chk("t4_c3_pop",   8'(pop),       8'h0);
        tick();
        out_ready = 1'b1; #1;
        chk("t4_c4_pop", 8'(pop), 8'h2);
        tick();
        out_ready = 1'b0; #1;
        chk("t4_c5_pop", 8'(pop), 8'h0);
        tick();
        out_ready = 1'b1; q_eop = 4'b0010; #1;
        chk("t4_c6_pop", 8'(pop), 8'h2);
        tick();
        q_empty = 4'b1001; q_eop = 4'hF; #1;
        chk("t4_c7_valid", 8'(out_valid), 8'd0);
        tick();
        chk("t4_c8_valid", 8'(out_valid), 8'd1);
        chk("t4_c8_id",    8'(out_id),    8'd2);

        // MAX_WORDS=4 without eop: 4 pops, len_err, resume at next slot
        apply_reset();
        q_empty = 4'b1110; q_eop = 4'h0; out_ready = 1'b1; reset = 1'b0; #1;
        chk("t5_c0_valid", 8'(out_valid), 8'd0);
        for (int w = 0; w < 4; w++) begin
            tick();
            chk("t5_pop",     8'(pop),     8'h1);
            chk("t5_len_low", 8'(len_err), 8'd0);
        end
        tick();
        q_empty = 4'b1100; #1;
        chk("t5_len_pulse", 8'(len_err),   8'd1);
        chk("t5_rel_valid", 8'(out_valid), 8'd0);
        tick();
        chk("t5_len_clear", 8'(len_err), 8'd0);
        chk("t5_next_id",   8'(out_id),  8'd1);
        chk("t5_next_pop",  8'(pop),     8'h2);
        tick();
        tick();
        tick();
        q_eop = 4'b0010; #1;
        chk("t5_eop_lim_pop", 8'(pop), 8'h2);
        tick();
        chk("t5_eop_lim_len",   8'(len_err),   8'd0);
        chk("t5_eop_lim_valid", 8'(out_valid), 8'd0);

        // Reset during second word of a grant; table and ptr restored
        apply_reset();
        q_empty = 4'hF; reset = 1'b0;
        cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = 2'd3; #1;
        tick();
        cfg_we = 1'b0; q_empty = 4'b1101; q_eop = 4'h0; out_ready = 1'b1; #1;
        chk("t6_c1_valid", 8'(out_valid), 8'd0);
        tick();
        chk("t6_w1_pop", 8'(pop), 8'h2);
        tick();
        reset = 1'b1; cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = 2'd3; #1;
        chk("t6_rst_pop",   8'(pop),       8'h0);
        chk("t6_rst_valid", 8'(out_valid), 8'd0);
        tick();
        reset = 1'b0; cfg_we = 1'b0; q_empty = 4'b0101; #1;
        chk("t6_r0_valid", 8'(out_valid), 8'd0);
        chk("t6_r0_id",    8'(out_id),    8'd0);
        tick();
        chk("t6_r1_valid", 8'(out_valid), 8'd0);
        tick();
        chk("t6_r2_valid", 8'(out_valid), 8'd1);
        chk("t6_r2_id",    8'(out_id),    8'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tlp_wrr_scheduler.md
# tlp_wrr_scheduler

Packet-level weighted round-robin scheduler for the TLP transmit path. It arbitrates between four per-class TLP queues and owns a 16-slot runtime-programmable priority table that sets the service order. The table pointer advances one slot per grant or skipped slot. Once a queue is granted, the block holds the grant until that queue's end-of-packet, pops words to the downstream link, and enforces a maximum packet length.

## Interface
Parameters:
- MAX_WORDS, default 16: maximum words per granted packet before forced release (2..255).

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- cfg_we  in  1  write enable, priority table
- cfg_addr  in  4  table slot to write
- cfg_data  in  2  queue id stored in slot
- q_empty  in  4  bit i = queue i empty
- q_eop  in  4  bit i = head word of queue i is last of packet
- out_ready  in  1  downstream accepts word this cycle
- pop  out  4  one-hot; bit i = dequeue head of queue i this cycle
- out_valid  out  1  word from granted queue is presented downstream
- out_id  out  2  id of granted queue
- len_err  out  1  one-cycle pulse on forced release (MAX_WORDS reached without eop)

## Operation
- State: table[16] x 2 bits, ptr (4 bits), fsm {SCAN, XFER}, gnt_id (2 bits), word_cnt (8 bits).
- Reset values: table[i] = i mod 4; ptr = 0; fsm = SCAN; gnt_id = 0; word_cnt = 0. Outputs: out_valid = 0, out_id = 0, pop = 0, len_err = 0.
- SCAN: q = table[ptr].
  - If q_empty[q] = 0: gnt_id <= q, word_cnt <= 0, fsm <= XFER. ptr is held.
  - Else ptr <= ptr + 1, wrapping 15 -> 0, and the block stays in SCAN.
  - When all queues are empty, the block scans one slot per cycle indefinitely.
- XFER (combinational from registered state):
  - out_id = gnt_id.
  - out_valid = ~q_empty[gnt_id].
  - pop[gnt_id] = out_valid & out_ready. All other pop bits are 0.
- On each pop: word_cnt <= word_cnt + 1.
  - If q_eop[gnt_id] = 1: fsm <= SCAN, ptr <= ptr + 1.
  - Else if word_cnt + 1 = MAX_WORDS: fsm <= SCAN, ptr <= ptr + 1, len_err <= 1 for one cycle.
  - eop takes precedence; no len_err when eop coincides with the limit.
- A queue that goes empty mid-packet stalls XFER with out_valid = 0. The grant is kept and no timeout applies.
- Table writes are accepted in any state:
  - A write to the slot being read in SCAN that same cycle takes effect on the next read; the current decision uses the old value.
  - A write to the slot of an active grant does not affect that grant.
- out_id is 0 and out_valid/pop are 0 in SCAN.

## Timing
- Grant latency: a queue found non-empty at slot ptr in SCAN cycle N gives out_valid = 1 and out_id valid in cycle N+1.
- First pop can occur in cycle N+1 if out_ready = 1.
- Back-to-back: the pop of an eop word in cycle M puts the block in SCAN in cycle M+1. The minimum inter-packet gap is one cycle.
- A skipped empty slot costs one cycle.
- pop, out_valid and out_id are combinational from registers and inputs q_empty, q_eop, out_ready. There is no input-to-register path on out_id.
- Reset mid-XFER: while reset = 1, pop = 0 and out_valid = 0 (forced combinationally). The packet is abandoned and all state returns to reset values on the next edge.
- cfg_we during reset is ignored.

## Test plan
- Default table, all four queues non-empty, 1-word packets (q_eop = 4'hF), out_ready = 1 -> out_id sequence 0,1,2,3,0... with one grant every 2 cycles; pop one-hot matching out_id.
- Program slots 0..15 as {0,0,0,1, 0,0,0,2, 0,0,0,3, 0,0,0,1}, all queues busy with 1-word packets -> over 16 grants, queue 0 is granted 12, queue 1 twice, queues 2 and 3 once each, in table order.
- Only queue 2 non-empty, default table, from reset -> slots 0,1 are skipped; out_valid = 1 with out_id = 2 in cycle 3 after reset release.
- Queue 1 packet of 3 words, out_ready toggling 1,0,1,0,1 -> three pops on the ready-high cycles only; release after the eop pop; ptr advances by 1.
- MAX_WORDS = 4, queue 0 with q_eop held 0 -> exactly 4 pops, then len_err pulses one cycle and scanning resumes at the next slot.
- Assert reset during the second word of a 5-word grant -> pop = 0 in the reset cycle; after reset out_id = 0 and ptr = 0, and the table returns to default even if reprogrammed.
